j1_io_ctrl: RTL and testbench
=============================

// Module: j1_io_ctrl
// PURPOSE
//   I/O controller between the j1 core's io_rd/io_wr port and its peripherals.
//   Decodes mem_addr into LED, UART data and status registers.
//   Buffers CPU TX bytes in a small FIFO and drains them into buart under the
//   busy handshake; captures RX bytes into a holding register.
//   Replaces direct io_wr->buart wiring, so firmware no longer spins per byte.
// PARAMETERS
//   TX_AW   3  log2 of TX FIFO depth (depth = 2**TX_AW = 8)
//   LED_W   5  width of LED output register
// PORTS
//   clk           in   1      system clock; all state on posedge
//   resetq        in   1      asynchronous, active-low reset
//   io_rd         in   1      j1 I/O read strobe, one cycle
//   io_wr         in   1      j1 I/O write strobe, one cycle
//   mem_addr      in   16     j1 I/O address; select = mem_addr[13:12]
//   dout          in   16     j1 write data
//   io_din        out  16     read data to j1, combinational from mem_addr/state
//   uart_wr       out  1      one-cycle TX start pulse to buart
//   uart_tx_data  out  8      TX byte, valid while uart_wr=1
//   uart_busy     in   1      buart transmitter busy
//   uart_valid    in   1      buart has an RX byte
//   uart_rx_data  in   8      buart RX byte
//   uart_rd       out  1      one-cycle RX acknowledge to buart
//   leds          out  LED_W  LED register
// BEHAVIOUR
//   Reset: leds=0, uart_wr=0, uart_rd=0, FIFO empty, rx_valid=0, rx_overrun=0,
//     tx_drop=0, TX FSM=IDLE. io_din is 0 when sel=3.
//   Address map (sel=mem_addr[13:12]): 0 LED, 1 UART data, 2 status, 3 reserved.
//     Reserved: reads 0, writes ignored.
//   LED: io_wr -> leds <= dout[LED_W-1:0] at the next edge; read returns leds,
//     zero-extended.
//   Status read: {11'b0, tx_drop, rx_overrun, rx_valid, tx_idle, tx_ready}.
//     tx_ready = !fifo_full.
//     tx_idle = fifo_empty & FSM==IDLE & !uart_busy.
//   Status write: dout[3]=1 clears rx_overrun, dout[4]=1 clears tx_drop (W1C).
//     Other bits are ignored.
//   Data write: pushes dout[7:0].
//     If full, and no pop occurs the same edge, drop the byte and set tx_drop.
//     If full and a pop occurs the same edge, accept the push.
//   Data read: io_din = {7'b0, rx_valid, rx_byte}; clears rx_valid at the edge.
//   TX FSM:
//     IDLE: if !empty & !uart_busy -> SEND.
//     SEND: uart_wr=1, uart_tx_data=head, pop -> GUARD.
//     GUARD: one cycle, covers buart busy latency -> IDLE.
//     Byte order is strictly FIFO; head-to-uart_wr is 1 cycle from IDLE.
//   Max throughput: one byte per 3 cycles when buart is never busy.
//   RX: on uart_valid, always pulse uart_rd for one cycle.
//     Capture uart_rx_data, set rx_valid.
//     If rx_valid is already set and not being read this cycle, keep the old
//     byte, discard the new one and set rx_overrun.
//     CPU read and new byte in the same cycle: the new byte is captured and
//     rx_valid stays 1, with no overrun.
//     uart_rd is not reasserted until uart_valid has dropped.
//   FIFO pointers are TX_AW+1 bits and wrap modulo 2**(TX_AW+1).
//     full  = ptr MSBs differ & rest equal.
//     empty = ptrs equal.
//   Reset mid-transfer aborts the FSM and flushes the FIFO; buart is unaffected.
//   io_rd and io_wr both high: the write takes effect; the read returns
//     pre-edge state.
// STRUCTURE
//   Package j1_io_pkg:
//     SEL_LED/SEL_UART/SEL_STAT/SEL_RSVD constants
//     status bit indices ST_TX_READY..ST_TX_DROP
//     TX FSM state enum {IDLE,SEND,GUARD}
//   Sub-module io_sync_fifo #(W=8, AW=TX_AW): push/pop/full/empty/head,
//     first-word-fall-through, async active-low reset.
//   Top level: address decode, LED register, RX holding logic, TX FSM.
// TESTING
//   1 Write 'H','i' to sel=1, uart_busy model 10 cycles/byte -> uart_wr pulses
//     carry 0x48 then 0x69; the second pulse comes after busy falls; tx_idle=1
//     afterwards.
//   2 Hold uart_busy=1, write 9 bytes -> first 8 are stored, tx_ready=0 after 8,
//     status reads 0x0010 (tx_drop), W1C 0x10 -> 0x0000.
//   3 Inject RX 0x41 -> uart_rd pulses once; data read returns 0x0141; second
//     read returns 0x0041 & 0xFF with rx_valid=0.
//   4 Two RX bytes 0x31, 0x32 with no read -> data read returns 0x0131,
//     rx_overrun=1; W1C dout=0x08 clears it.
//   5 Full FIFO with push on the same edge as the SEND pop -> byte accepted,
//     tx_drop stays 0; full 8-byte order preserved.
//   6 Assert resetq=0 in SEND with 4 queued -> uart_wr=0 at once; after release
//     status=0x0003 and leds=0.

Source files
------------

// File: rtl/j1_io_pkg.sv
// Shared constants for the j1 I/O controller.
// Address selects, status bit positions and TX FSM states.
package j1_io_pkg;

    localparam logic [1:0] SEL_LED  = 2'd0;
    localparam logic [1:0] SEL_UART = 2'd1;
    localparam logic [1:0] SEL_STAT = 2'd2;
    localparam logic [1:0] SEL_RSVD = 2'd3;

    localparam int ST_TX_READY   = 0;
    localparam int ST_TX_IDLE    = 1;
    localparam int ST_RX_VALID   = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_TX_DROP    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2
    } tx_state_e;

endpackage

// File: rtl/j1_io_ctrl_fifo.sv
// Small synchronous FIFO, first-word-fall-through.
// Caller guarantees no push when full (unless popping) and no pop when empty.
module io_sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/j1_io_ctrl.sv
// j1 I/O controller: LED register, UART RX holding register,
// buffered UART TX with a busy-aware send FSM.
module j1_io_ctrl
    import j1_io_pkg::*;
#(
    parameter int TX_AW = 3,
    parameter int LED_W = 5
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             io_rd,
    input  logic             io_wr,
    input  logic [15:0]      mem_addr,
    input  logic [15:0]      dout,
    output logic [15:0]      io_din,
    output logic             uart_wr,
    output logic [7:0]       uart_tx_data,
    input  logic             uart_busy,
    input  logic             uart_valid,
    input  logic [7:0]       uart_rx_data,
    output logic             uart_rd,
    output logic [LED_W-1:0] leds
);

    logic [1:0] sel;
    logic       wr_led, wr_data, wr_stat, rd_data;

    tx_state_e  state_q, state_d;
    logic       pop, push, drop;
    logic       fifo_full, fifo_empty;
    logic [7:0] fifo_head;

    logic [LED_W-1:0] leds_q, leds_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_ovr_q, rx_ovr_d;
    logic             tx_drop_q, tx_drop_d;
    logic             uart_rd_q, uart_rd_d;
    logic             rx_prev_q, rx_prev_d;
    logic             rx_take, rx_accept;

    logic [15:0] status;
    logic        unused_bits;

    assign unused_bits = ^{mem_addr[15:14], mem_addr[11:0], dout[15:8]};

    assign sel     = mem_addr[13:12];
    assign wr_led  = io_wr && (sel == SEL_LED);
    assign wr_data = io_wr && (sel == SEL_UART);
    assign wr_stat = io_wr && (sel == SEL_STAT);
    assign rd_data = io_rd && (sel == SEL_UART);

    // A full FIFO still accepts a byte on the edge that pops the head.
    assign push = wr_data && (!fifo_full || pop);
    assign drop = wr_data && fifo_full && !pop;

    io_sync_fifo #(
        .W  (8),
        .AW (TX_AW)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (resetq),
        .push  (push),
        .pop   (pop),
        .din   (dout[7:0]),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        uart_wr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && !uart_busy) state_d = SEND;
            end
            SEND: begin
                uart_wr = 1'b1;
                pop     = 1'b1;
                state_d = GUARD;
            end
            GUARD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign uart_tx_data = fifo_head;

    // Take a byte once per uart_valid assertion; edge-detect on valid.
    assign rx_take   = uart_valid && !rx_prev_q;
    assign rx_accept = rx_take && (!rx_valid_q || rd_data);

    always_comb begin
        leds_d     = leds_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        tx_drop_d  = tx_drop_q;
        uart_rd_d  = rx_take;
        rx_prev_d  = uart_valid;

        if (wr_led) leds_d = dout[LED_W-1:0];

        if (wr_stat && dout[ST_RX_OVERRUN]) rx_ovr_d  = 1'b0;
        if (wr_stat && dout[ST_TX_DROP])    tx_drop_d = 1'b0;
        if (drop) tx_drop_d = 1'b1;

        if (rx_accept) begin
            rx_byte_d  = uart_rx_data;
            rx_valid_d = 1'b1;
        end else if (rx_take) begin
            rx_ovr_d   = 1'b1;
        end else if (rd_data) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q    <= IDLE;
            leds_q     <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_drop_q  <= 1'b0;
            uart_rd_q  <= 1'b0;
            rx_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            leds_q     <= leds_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_drop_q  <= tx_drop_d;
            uart_rd_q  <= uart_rd_d;
            rx_prev_q  <= rx_prev_d;
        end
    end

    assign uart_rd = uart_rd_q;
    assign leds    = leds_q;

    always_comb begin
        status                = '0;
        status[ST_TX_READY]   = !fifo_full;
        status[ST_TX_IDLE]    = fifo_empty && (state_q == IDLE) && !uart_busy;
        status[ST_RX_VALID]   = rx_valid_q;
        status[ST_RX_OVERRUN] = rx_ovr_q;
        status[ST_TX_DROP]    = tx_drop_q;
    end

    always_comb begin
        io_din = '0;
        unique case (sel)
            SEL_LED:  io_din = 16'(leds_q);
            SEL_UART: io_din = {7'b0, rx_valid_q, rx_byte_q};
            SEL_STAT: io_din = status;
            SEL_RSVD: io_din = '0;
            default:  io_din = '0;
        endcase
    end

endmodule

// File: tb/tb_j1_io_ctrl.sv
// Bench for j1_io_ctrl: directed scenarios plus random traffic,
// checked against a queue-based behavioural model.
module tb_j1_io_ctrl;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic        io_rd = 1'b0;
    logic        io_wr = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] dout = '0;
    logic        uart_busy = 1'b0;
    logic        uart_valid = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic [15:0] io_din;
    logic        uart_wr;
    logic [7:0]  uart_tx_data;
    logic        uart_rd;
    logic [4:0]  leds;

    always #5 clk = ~clk;

    j1_io_ctrl #(.TX_AW(3), .LED_W(5)) dut (
        .clk          (clk),
        .resetq       (resetq),
        .io_rd        (io_rd),
        .io_wr        (io_wr),
        .mem_addr     (mem_addr),
        .dout         (dout),
        .io_din       (io_din),
        .uart_wr      (uart_wr),
        .uart_tx_data (uart_tx_data),
        .uart_busy    (uart_busy),
        .uart_valid   (uart_valid),
        .uart_rx_data (uart_rx_data),
        .uart_rd      (uart_rd),
        .leds         (leds)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    byte unsigned m_q[$];
    int           m_tx = 0;      // cycles left in current transfer: 2 send, 1 guard
    bit           m_rxv, m_ovr, m_drop, m_rd, m_prev_valid;
    byte unsigned m_rxb;
    logic [15:0]  m_leds;

    // Stimulus-side state
    int           busy_len = 0;
    int           busy_cnt = 0;
    bit           force_busy = 0;
    byte unsigned tx_log[$];
    int           rd_cnt = 0;
    logic [15:0]  obs_din;

    task automatic model_reset();
        m_q.delete();
        m_tx = 0;
        m_rxv = 0; m_ovr = 0; m_drop = 0; m_rd = 0; m_prev_valid = 0;
        m_rxb = 0;
        m_leds = 0;
    endtask

    function automatic logic [15:0] exp_status();
        logic [15:0] s;
        s = '0;
        s[0] = m_q.size() < 8;
        s[1] = (m_q.size() == 0) && (m_tx == 0) && !uart_busy;
        s[2] = m_rxv;
        s[3] = m_ovr;
        s[4] = m_drop;
        return s;
    endfunction

    function automatic logic [15:0] exp_din();
        case (mem_addr[13:12])
            2'd0:    return m_leds;
            2'd1:    return {7'b0, m_rxv, m_rxb};
            2'd2:    return exp_status();
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_step();
        logic [1:0] s;
        bit pop, take, rd_d;
        int nxt;
        s    = mem_addr[13:12];
        pop  = (m_tx == 2);
        rd_d = io_rd && (s == 2'd1);
        take = uart_valid && !m_prev_valid;
        if (m_tx > 0) nxt = m_tx - 1;
        else nxt = (m_q.size() != 0 && !uart_busy) ? 2 : 0;
        if (io_wr && s == 2'd2) begin
            if (dout[3]) m_ovr = 0;
            if (dout[4]) m_drop = 0;
        end
        if (pop) void'(m_q.pop_front());
        if (io_wr && s == 2'd1) begin
            if (m_q.size() < 8) m_q.push_back(dout[7:0]);
            else m_drop = 1;
        end
        m_tx = nxt;
        if (io_wr && s == 2'd0) m_leds = dout & 16'h001F;
        m_rd = take;
        if (take) begin
            if (!m_rxv || rd_d) begin
                m_rxb = uart_rx_data;
                m_rxv = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (rd_d) begin
            m_rxv = 0;
        end
        m_prev_valid = uart_valid;
    endtask

    task automatic cycle();
        bit wr_now, rd_now;
        @(negedge clk);
        check("io_din", io_din, exp_din());
        check("uart_wr", 16'(uart_wr), 16'(m_tx == 2));
        if (m_tx == 2 && m_q.size() > 0)
            check("tx_data", 16'(uart_tx_data), 16'(m_q[0]));
        check("uart_rd", 16'(uart_rd), 16'(m_rd));
        check("leds", 16'(leds), m_leds);
        obs_din = io_din;
        if (uart_wr) tx_log.push_back(uart_tx_data);
        if (uart_rd) rd_cnt++;
        wr_now = (m_tx == 2);
        rd_now = m_rd;
        @(posedge clk);
        model_step();
        #1;
        if (wr_now) busy_cnt = busy_len;
        else if (busy_cnt > 0) busy_cnt--;
        uart_busy = force_busy || (busy_cnt > 0);
        if (uart_valid && rd_now) uart_valid = 0;
        io_rd = 0;
        io_wr = 0;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic io_write(logic [1:0] s, logic [15:0] d);
        mem_addr = {2'b00, s, 12'h000};
        dout = d;
        io_wr = 1;
        cycle();
    endtask

    task automatic io_read(logic [1:0] s);
        mem_addr = {2'b00, s, 12'h000};
        io_rd = 1;
        cycle();
    endtask

    task automatic rx_send(byte unsigned b);
        int n;
        n = 0;
        while ((uart_valid || m_prev_valid) && n < 20) begin
            cycle();
            n++;
        end
        if (n >= 20) check("rx_wait_timeout", 16'(uart_valid), 16'h0000);
        uart_valid = 1;
        uart_rx_data = b;
    endtask

    task automatic hold_busy(bit b);
        force_busy = b;
        uart_busy = b || (busy_cnt > 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 resetq = 1;

        // Reset state
        io_read(2'd2);
        check("rst_status", obs_din, 16'h0003);
        io_read(2'd3);
        check("rst_rsvd", obs_din, 16'h0000);
        io_write(2'd0, 16'hFFF6);
        io_read(2'd0);
        check("led_rd", obs_din, 16'h0016);
        io_write(2'd3, 16'hFFFF);

        // 1: two bytes under a 10-cycle busy
        busy_len = 10;
        tx_log.delete();
        io_write(2'd1, 16'h0048);
        io_write(2'd1, 16'h0069);
        idle(40);
        check("t1_count", 16'(tx_log.size()), 16'd2);
        check("t1_b0", tx_log.size() > 0 ? 16'(tx_log[0]) : 16'hFFFF, 16'h0048);
        check("t1_b1", tx_log.size() > 1 ? 16'(tx_log[1]) : 16'hFFFF, 16'h0069);
        io_read(2'd2);
        check("t1_status", obs_din, 16'h0003);

        // 2: overflow while busy, then W1C drop flag
        busy_len = 0;
        hold_busy(1);
        for (int i = 0; i < 9; i++) io_write(2'd1, 16'(8'hA0 + i));
        io_read(2'd2);
        check("t2_status", obs_din, 16'h0010);
        io_write(2'd2, 16'h0010);
        io_read(2'd2);
        check("t2_w1c", obs_din, 16'h0000);
        tx_log.delete();
        hold_busy(0);
        idle(40);
        check("t2_count", 16'(tx_log.size()), 16'd8);
        for (int i = 0; i < 8; i++)
            check("t2_order", i < tx_log.size() ? 16'(tx_log[i]) : 16'hFFFF,
                  16'(8'hA0 + i));

        // 3: single RX byte
        rd_cnt = 0;
        rx_send(8'h41);
        idle(4);
        check("t3_rd_pulses", 16'(rd_cnt), 16'd1);
        io_read(2'd1);
        check("t3_read1", obs_din, 16'h0141);
        io_read(2'd1);
        check("t3_read2", obs_din, 16'h0041);

        // 4: overrun
        rx_send(8'h31);
        idle(3);
        rx_send(8'h32);
        idle(4);
        io_read(2'd2);
        check("t4_status", obs_din, 16'h000F);
        io_read(2'd1);
        check("t4_data", obs_din, 16'h0131);
        io_write(2'd2, 16'h0008);
        io_read(2'd2);
        check("t4_w1c", obs_din, 16'h0003);

        // 5: push into a full FIFO on the pop edge
        hold_busy(1);
        for (int i = 0; i < 8; i++) io_write(2'd1, 16'(8'hB0 + i));
        tx_log.delete();
        hold_busy(0);
        idle(1);
        io_write(2'd1, 16'h00B8);
        io_read(2'd2);
        check("t5_status", obs_din, 16'h0000);
        idle(40);
        check("t5_count", 16'(tx_log.size()), 16'd9);
        for (int i = 0; i < 9; i++)
            check("t5_order", i < tx_log.size() ? 16'(tx_log[i]) : 16'hFFFF,
                  16'(8'hB0 + i));

        // 6: reset while sending
        io_write(2'd0, 16'h0015);
        hold_busy(1);
        for (int i = 0; i < 4; i++) io_write(2'd1, 16'(8'hC0 + i));
        hold_busy(0);
        idle(1);
        resetq = 0;
        #1;
        check("t6_uart_wr", 16'(uart_wr), 16'h0000);
        check("t6_uart_rd", 16'(uart_rd), 16'h0000);
        check("t6_leds", 16'(leds), 16'h0000);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 resetq = 1;
        io_read(2'd2);
        check("t6_status", obs_din, 16'h0003);
        idle(10);

        // Random traffic
        busy_len = 4;
        for (int i = 0; i < 1500; i++) begin
            int op;
            op = $urandom_range(0, 9);
            mem_addr = 16'($urandom);
            dout = 16'($urandom);
            io_wr = (op < 4);
            io_rd = (op >= 3 && op < 7);
            if (!uart_valid && !m_prev_valid && $urandom_range(0, 5) == 0) begin
                uart_valid = 1;
                uart_rx_data = 8'($urandom);
            end
            if ($urandom_range(0, 99) == 0) hold_busy(!force_busy);
            if ($urandom_range(0, 199) == 0) busy_len = $urandom_range(0, 12);
            cycle();
        end
        hold_busy(0);
        idle(120);
        io_read(2'd2);
        check("final_status", obs_din, exp_status());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
